// File: rtl/prog_freq_divider.sv
// Programmable modulo-N counter / clock divider with a shadowed modulus that takes effect on wrap.
// Optional macro DIV_SQUARE_EN: fout is a ~50% square wave instead of a registered tc pulse.
module prog_freq_divider #(
    parameter int WIDTH   = 4,
    parameter int DEF_MOD = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] mod_in,
    input  logic             mod_load,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             fout,
    output logic             mod_pending,
    output logic             mod_err
);

    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] DEF_N   = WIDTH'(DEF_MOD);

    logic [WIDTH-1:0] n_act;
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH-1:0] n_nxt;
    logic [WIDTH-1:0] shadow_nxt;
    logic             pend_nxt;
    logic             load_ok;
    logic             wrap;

    assign load_ok = mod_load && (mod_in != '0);
    assign wrap    = en && (count == n_act - ONE);
    assign tc      = wrap;

    // A valid load landing on the wrap edge bypasses the shadow and wins over any pending value.
    always_comb begin
        cnt_nxt    = count;
        n_nxt      = n_act;
        shadow_nxt = shadow;
        pend_nxt   = mod_pending;
        if (load_ok) begin
            shadow_nxt = mod_in;
            pend_nxt   = 1'b1;
        end
        if (wrap) begin
            cnt_nxt  = '0;
            pend_nxt = 1'b0;
            if (load_ok) begin
                n_nxt = mod_in;
            end else if (mod_pending) begin
                n_nxt = shadow;
            end
        end else if (en) begin
            cnt_nxt = count + ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count       <= '0;
            n_act       <= DEF_N;
            shadow      <= DEF_N;
            mod_pending <= 1'b0;
            mod_err     <= 1'b0;
        end else begin
            count       <= cnt_nxt;
            n_act       <= n_nxt;
            shadow      <= shadow_nxt;
            mod_pending <= pend_nxt;
            mod_err     <= mod_load && (mod_in == '0);
        end
    end

`ifdef DIV_SQUARE_EN
    // Precomputed from next-state so fout stays a pure register aligned with count.
    logic [WIDTH:0] half_nxt;
    assign half_nxt = ({1'b0, n_nxt} + (WIDTH+1)'(1)) >> 1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fout <= 1'b1;
        end else begin
            fout <= ({1'b0, cnt_nxt} < half_nxt);
        end
    end
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fout <= 1'b0;
        end else begin
            fout <= tc;
        end
    end
`endif

endmodule
